// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - opcode constants for the supported instruction set
//   - ALU operation, ALU B-source and PC-source mux codes
//   - state_t: control FSM state encoding (4-bit)
//   - op_supported(): true when the control FSM knows how to execute an opcode
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_REXEC  = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_IEXEC  = 4'd11,
        ST_IWB    = 4'd12
    } state_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Output decoder for the multicycle control FSM: purely combinational
// map from the current state (and effective memory-ready) to every
// datapath control except illegal_op, which depends on the opcode.
// Ports:
//   i_state      current FSM state
//   i_mem_ready  effective memory-ready (already forced to 1 when no handshake)
//   o_*          datapath enables / mux selects, instr_done pulse
module multicycle_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t      i_state,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_pc_write_cond,
    output logic        o_iord,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_mem_to_reg,
    output logic        o_reg_dst,
    output logic        o_reg_write,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic [1:0]  o_pc_source,
    output logic        o_instr_done
);

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_REG;
        o_alu_op        = ALUOP_ADD;
        o_pc_source     = PCSRC_ALU;
        o_instr_done    = 1'b0;

        case (i_state)
            ST_FETCH: begin
                // Memory read held through the stall; IR and PC update
                // only in the cycle the fetch actually completes.
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH2;
            end
            ST_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            ST_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_instr_done = 1'b1;
            end
            ST_MEMWR: begin
                o_mem_write  = 1'b1;
                o_iord       = 1'b1;
                o_instr_done = i_mem_ready;
            end
            ST_REXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = 1'b1;
                o_instr_done = 1'b1;
            end
            ST_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
                o_instr_done    = 1'b1;
            end
            ST_JUMP: begin
                o_pc_write   = 1'b1;
                o_pc_source  = PCSRC_JUMP;
                o_instr_done = 1'b1;
            end
            ST_IEXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            ST_IWB: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq,
// j, addi) with an optional memory-ready stall handshake.
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   op             opcode from the instruction register
//   mem_ready      memory access completes this cycle
//   PCWrite .. PCSource   datapath controls (see outdec)
//   instr_done     pulse in the final cycle of each instruction
//   illegal_op     pulse in DECODE for an unsupported opcode
//
// state  | meaning
// IDLE   | after reset, all outputs low
// FETCH  | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE | register read, branch target precompute, dispatch on op
// MEMADR | lw/sw effective address
// MEMRD  | lw data read (waits on mem_ready)
// MEMWB  | lw write-back from MDR
// MEMWR  | sw data write (waits on mem_ready)
// REXEC  | R-type ALU operation
// RWB    | R-type write-back to rd
// BRANCH | beq compare and conditional PC load
// JUMP   | j PC load
// IEXEC  | addi ALU operation
// IWB    | addi write-back to rt
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  Alu_op,
    output logic [1:0]  PCSource,
    output logic        instr_done,
    output logic        illegal_op
);

    state_t r_state;
    state_t w_next_state;
    logic   w_mem_ready;

    assign w_mem_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = w_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    OP_RTYPE:     w_next_state = ST_REXEC;
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_J:         w_next_state = ST_JUMP;
                    OP_ADDI:      w_next_state = ST_IEXEC;
                    default:      w_next_state = ST_FETCH;
                endcase
            end
            // op is still valid here: the IR only loads in FETCH.
            ST_MEMADR: w_next_state = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  w_next_state = w_mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_next_state = ST_FETCH;
            ST_MEMWR:  w_next_state = w_mem_ready ? ST_FETCH : ST_MEMWR;
            ST_REXEC:  w_next_state = ST_RWB;
            ST_RWB:    w_next_state = ST_FETCH;
            ST_BRANCH: w_next_state = ST_FETCH;
            ST_JUMP:   w_next_state = ST_FETCH;
            ST_IEXEC:  w_next_state = ST_IWB;
            ST_IWB:    w_next_state = ST_FETCH;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    assign illegal_op = (r_state == ST_DECODE) && !op_supported(op);

    multicycle_ctrl_outdec u_outdec (
        .i_state         (r_state),
        .i_mem_ready     (w_mem_ready),
        .o_pc_write      (PCWrite),
        .o_pc_write_cond (PCWriteCond),
        .o_iord          (IorD),
        .o_mem_read      (MemRead),
        .o_mem_write     (MemWrite),
        .o_ir_write      (IRWrite),
        .o_mem_to_reg    (MemtoReg),
        .o_reg_dst       (RegDst),
        .o_reg_write     (RegWrite),
        .o_alu_src_a     (ALUSrcA),
        .o_alu_src_b     (ALUSrcB),
        .o_alu_op        (Alu_op),
        .o_pc_source     (PCSource),
        .o_instr_done    (instr_done)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    typedef logic [17:0] vec_t;

    typedef struct {
        logic       rdy;
        logic [5:0] opv;
        logic       sel0;
        vec_t       exp;
        string      name;
    } item_t;

    // Output vector bit positions
    localparam int B_PCW   = 17;
    localparam int B_PCWC  = 16;
    localparam int B_IORD  = 15;
    localparam int B_MRD   = 14;
    localparam int B_MWR   = 13;
    localparam int B_IRW   = 12;
    localparam int B_M2R   = 11;
    localparam int B_RDST  = 10;
    localparam int B_RWR   = 9;
    localparam int B_SRCA  = 8;
    localparam int B_DONE  = 1;
    localparam int B_ILL   = 0;

    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3,
                   PH_MEMRD = 4, PH_MEMWB = 5, PH_MEMWR = 6, PH_REXEC = 7,
                   PH_RWB = 8, PH_BRANCH = 9, PH_JUMP = 10, PH_IEXEC = 11,
                   PH_IWB = 12;

    logic       clk = 1'b0;
    logic       rst_n, rst0_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       mr0;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, Alu_op, PCSource;

    logic       PCWrite0, PCWriteCond0, IorD0, MemRead0, MemWrite0, IRWrite0;
    logic       MemtoReg0, RegDst0, RegWrite0, ALUSrcA0, instr_done0, illegal_op0;
    logic [1:0] ALUSrcB0, Alu_op0, PCSource0;

    vec_t got, got0;
    item_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Alu_op(Alu_op),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .op(op), .mem_ready(mr0),
        .PCWrite(PCWrite0), .PCWriteCond(PCWriteCond0), .IorD(IorD0),
        .MemRead(MemRead0), .MemWrite(MemWrite0), .IRWrite(IRWrite0),
        .MemtoReg(MemtoReg0), .RegDst(RegDst0), .RegWrite(RegWrite0),
        .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .Alu_op(Alu_op0),
        .PCSource(PCSource0), .instr_done(instr_done0), .illegal_op(illegal_op0)
    );

    assign got  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, Alu_op,
                   PCSource, instr_done, illegal_op};
    assign got0 = {PCWrite0, PCWriteCond0, IorD0, MemRead0, MemWrite0, IRWrite0,
                   MemtoReg0, RegDst0, RegWrite0, ALUSrcA0, ALUSrcB0, Alu_op0,
                   PCSource0, instr_done0, illegal_op0};

    // Expected output vector for a state, written from the control table.
    // r is mem_ready for FETCH/MEMWR and the illegal flag for DECODE.
    function automatic vec_t ev(input int ph, input logic r);
        vec_t v;
        v = '0;
        case (ph)
            PH_FETCH:  begin v[B_MRD] = 1'b1; v[7:6] = 2'b01; v[B_IRW] = r; v[B_PCW] = r; end
            PH_DECODE: begin v[7:6] = 2'b11; v[B_ILL] = r; end
            PH_MEMADR: begin v[B_SRCA] = 1'b1; v[7:6] = 2'b10; end
            PH_MEMRD:  begin v[B_MRD] = 1'b1; v[B_IORD] = 1'b1; end
            PH_MEMWB:  begin v[B_RWR] = 1'b1; v[B_M2R] = 1'b1; v[B_DONE] = 1'b1; end
            PH_MEMWR:  begin v[B_MWR] = 1'b1; v[B_IORD] = 1'b1; v[B_DONE] = r; end
            PH_REXEC:  begin v[B_SRCA] = 1'b1; v[5:4] = 2'b10; end
            PH_RWB:    begin v[B_RWR] = 1'b1; v[B_RDST] = 1'b1; v[B_DONE] = 1'b1; end
            PH_BRANCH: begin v[B_SRCA] = 1'b1; v[5:4] = 2'b01; v[B_PCWC] = 1'b1;
                             v[3:2] = 2'b01; v[B_DONE] = 1'b1; end
            PH_JUMP:   begin v[B_PCW] = 1'b1; v[3:2] = 2'b10; v[B_DONE] = 1'b1; end
            PH_IEXEC:  begin v[B_SRCA] = 1'b1; v[7:6] = 2'b10; end
            PH_IWB:    begin v[B_RWR] = 1'b1; v[B_DONE] = 1'b1; end
            default:   v = '0;
        endcase
        return v;
    endfunction

    task automatic push(input logic rdy, input logic [5:0] opv, input logic sel0,
                        input int ph, input logic r, input string nm);
        item_t it;
        it.rdy  = rdy;
        it.opv  = opv;
        it.sel0 = sel0;
        it.exp  = ev(ph, r);
        it.name = nm;
        sb.push_back(it);
    endtask

    // Drive inputs just after a rising edge, sample on the falling edge.
    task automatic run_cycle(input logic rdy, input logic [5:0] opv,
                             output vec_t o, output vec_t o0);
        mem_ready = rdy;
        op        = opv;
        @(negedge clk);
        o  = got;
        o0 = got0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst0_n = 1'b0; op = 6'b000000; mem_ready = 1'b1; mr0 = 1'b0;
        #12;
        total++;
        if (got !== 18'h0) begin
            bad++; $display("FAIL reset_outputs: got=%h want=%h", got, 18'h0);
        end
        total++;
        if (got0 !== 18'h0) begin
            bad++; $display("FAIL reset_outputs_nohs: got=%h want=%h", got0, 18'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        item_t it; vec_t o, o0, obs;
        push(1, 6'b000000, 0, PH_IDLE,   0, "rt_idle");
        push(1, 6'b000000, 0, PH_FETCH,  1, "rt_fetch");
        push(1, 6'b000000, 0, PH_DECODE, 0, "rt_decode");
        push(1, 6'b000000, 0, PH_REXEC,  0, "rt_rexec");
        push(1, 6'b000000, 0, PH_RWB,    0, "rt_rwb");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_lw_stall();
        item_t it; vec_t o, o0, obs;
        push(1, 6'b100011, 0, PH_FETCH,  1, "lw_fetch");
        push(1, 6'b100011, 0, PH_DECODE, 0, "lw_decode");
        push(1, 6'b100011, 0, PH_MEMADR, 0, "lw_memadr");
        push(0, 6'b100011, 0, PH_MEMRD,  0, "lw_memrd_stall1");
        push(0, 6'b100011, 0, PH_MEMRD,  0, "lw_memrd_stall2");
        push(1, 6'b100011, 0, PH_MEMRD,  0, "lw_memrd_ready");
        push(1, 6'b100011, 0, PH_MEMWB,  0, "lw_memwb");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_fetch_stall_addi();
        item_t it; vec_t o, o0, obs;
        for (int i = 0; i < 3; i++) push(0, 6'b001000, 0, PH_FETCH, 0, "fetch_stall");
        push(1, 6'b001000, 0, PH_FETCH,  1, "fetch_ready");
        push(1, 6'b001000, 0, PH_DECODE, 0, "addi_decode");
        push(1, 6'b001000, 0, PH_IEXEC,  0, "addi_iexec");
        push(1, 6'b001000, 0, PH_IWB,    0, "addi_iwb");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_sw_stall();
        item_t it; vec_t o, o0, obs;
        push(1, 6'b101011, 0, PH_FETCH,  1, "sw_fetch");
        push(1, 6'b101011, 0, PH_DECODE, 0, "sw_decode");
        push(1, 6'b101011, 0, PH_MEMADR, 0, "sw_memadr");
        push(0, 6'b101011, 0, PH_MEMWR,  0, "sw_memwr_stall");
        push(1, 6'b101011, 0, PH_MEMWR,  1, "sw_memwr_ready");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_branch_jump();
        item_t it; vec_t o, o0, obs;
        push(1, 6'b000100, 0, PH_FETCH,  1, "beq_fetch");
        push(1, 6'b000100, 0, PH_DECODE, 0, "beq_decode");
        push(1, 6'b000100, 0, PH_BRANCH, 0, "beq_branch");
        push(1, 6'b000010, 0, PH_FETCH,  1, "j_fetch");
        push(1, 6'b000010, 0, PH_DECODE, 0, "j_decode");
        push(1, 6'b000010, 0, PH_JUMP,   0, "j_jump");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_illegal();
        item_t it; vec_t o, o0, obs;
        push(1, 6'b111111, 0, PH_FETCH,  1, "ill_fetch");
        push(1, 6'b111111, 0, PH_DECODE, 1, "ill_decode");
        push(1, 6'b000001, 0, PH_FETCH,  1, "ill_refetch");
        push(1, 6'b000001, 0, PH_DECODE, 1, "ill2_decode");
        push(1, 6'b000000, 0, PH_FETCH,  1, "ill2_refetch");
        push(1, 6'b000000, 0, PH_DECODE, 0, "rt2_decode");
        push(1, 6'b000000, 0, PH_REXEC,  0, "rt2_rexec");
        push(1, 6'b000000, 0, PH_RWB,    0, "rt2_rwb");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic test_reset_mid_memwr();
        item_t it; vec_t o, o0, obs;
        push(1, 6'b101011, 0, PH_FETCH,  1, "rsw_fetch");
        push(1, 6'b101011, 0, PH_DECODE, 0, "rsw_decode");
        push(1, 6'b101011, 0, PH_MEMADR, 0, "rsw_memadr");
        push(0, 6'b101011, 0, PH_MEMWR,  0, "rsw_memwr_stall");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
        // Still in MEMWR (stalled); reset lands between clock edges.
        mem_ready = 1'b0;
        #1;
        total++;
        if (MemWrite !== 1'b1) begin
            bad++; $display("FAIL memwr_before_rst: got=%b want=1", MemWrite);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (got !== 18'h0) begin
            bad++; $display("FAIL rst_mid_memwr: got=%h want=%h", got, 18'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(1, 6'b100011, 0, PH_IDLE,   0, "post_rst_idle");
        push(1, 6'b100011, 0, PH_FETCH,  1, "post_rst_fetch");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
        // Handshake disabled, mem_ready tied 0: lw still completes in 5 cycles.
        rst0_n = 1'b1;
        push(0, 6'b100011, 1, PH_IDLE,   0, "nohs_idle");
        push(0, 6'b100011, 1, PH_FETCH,  1, "nohs_fetch");
        push(0, 6'b100011, 1, PH_DECODE, 0, "nohs_decode");
        push(0, 6'b100011, 1, PH_MEMADR, 0, "nohs_memadr");
        push(0, 6'b100011, 1, PH_MEMRD,  0, "nohs_memrd");
        push(0, 6'b100011, 1, PH_MEMWB,  0, "nohs_memwb");
        push(0, 6'b000000, 1, PH_FETCH,  1, "nohs_refetch");
        while (sb.size() > 0) begin
            it = sb.pop_front();
            run_cycle(it.rdy, it.opv, o, o0);
            obs = it.sel0 ? o0 : o;
            total++;
            if (obs !== it.exp) begin
                bad++; $display("FAIL %s: got=%h want=%h", it.name, obs, it.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_fetch_stall_addi();
        test_sw_stall();
        test_branch_jump();
        test_illegal();
        test_reset_mid_memwr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
